// File: rtl/fixpoint_reach_engine_pkg.sv
// Shared types for the reachability fixpoint engine: result status, propagation
// mode and controller state encodings.
package fixpoint_pkg;

    typedef enum logic [1:0] {
        SAFE      = 2'b00,
        VIOLATION = 2'b01,
        TIMEOUT   = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        LEFT  = 2'b00,
        RIGHT = 2'b01,
        BOTH  = 2'b10,
        HOLD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } fsm_e;

endpackage

// File: rtl/fixpoint_reach_engine_if.sv
// Job request / result handshake bundle between a requester (master) and the
// fixpoint engine (slave).
interface fixpoint_reach_engine_if #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] bad;
    logic [1:0]       mode;
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_status;
    logic [WIDTH-1:0] res_state;
    logic [CNT_W-1:0] res_iters;

    modport master (
        output start_valid, init, mask, bad, mode, res_ready,
        input  start_ready, res_valid, res_status, res_state, res_iters
    );

    modport slave (
        input  start_valid, init, mask, bad, mode, res_ready,
        output start_ready, res_valid, res_status, res_state, res_iters
    );
endinterface

// File: rtl/fixpoint_reach_engine_next_state.sv
// One masked shift-propagation step: next = state | (P & mask), P selected by mode.
// Purely combinational so several copies can be chained per cycle later.
module fixpoint_next_state
    import fixpoint_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter bit WRAP  = 1'b0
) (
    input  logic [WIDTH-1:0] state_i,
    input  logic [WIDTH-1:0] mask_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] next_o
);
    logic             fill_l;
    logic             fill_r;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] prop;

    // Edge bits see zero, or the opposite end of the vector when rotating
    assign fill_l = WRAP ? state_i[WIDTH-1] : 1'b0;
    assign fill_r = WRAP ? state_i[0]       : 1'b0;
    assign left   = {state_i[WIDTH-2:0], fill_l};
    assign right  = {fill_r, state_i[WIDTH-1:1]};

    always_comb begin
        prop = '0;
        case (mode_i)
            LEFT:    prop = left;
            RIGHT:   prop = right;
            BOTH:    prop = left | right;
            default: prop = '0;
        endcase
    end

    assign next_o = state_i | (prop & mask_i);

endmodule

// File: rtl/fixpoint_reach_engine.sv
// Iterates the masked propagation step one update per clock until the state is a
// fixpoint, hits a bad bit, or the iteration bound is reached; result via valid/ready.
module fixpoint_reach_engine
    import fixpoint_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int MAX_ITERS = WIDTH + 1,
    parameter bit WRAP      = 1'b0,
    parameter int CNT_W     = $clog2(MAX_ITERS + 1)
) (
    input logic                     clk,
    input logic                     rst,
    fixpoint_reach_engine_if.slave  bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITERS);

    fsm_e             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] bad_q;
    mode_e            mode_q;
    logic [CNT_W-1:0] iters_q;
    status_e          status_q;
    logic             valid_q;
    logic             ready_q;
    logic [WIDTH-1:0] next_state_d;

    fixpoint_next_state #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_next (
        .state_i (state_q),
        .mask_i  (mask_q),
        .mode_i  (mode_q),
        .next_o  (next_state_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q    <= S_IDLE;
            state_q  <= '0;
            mask_q   <= '0;
            bad_q    <= '0;
            mode_q   <= LEFT;
            iters_q  <= '0;
            status_q <= SAFE;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        state_q <= bus.init;
                        mask_q  <= bus.mask;
                        bad_q   <= bus.bad;
                        mode_q  <= mode_e'(bus.mode);
                        iters_q <= '0;
                        ready_q <= 1'b0;
                        fsm_q   <= S_ITER;
                    end
                end
                S_ITER: begin
                    if ((state_q & bad_q) != '0) begin
                        status_q <= VIOLATION;
                        fsm_q    <= S_DONE;
                    end else if (next_state_d == state_q) begin
                        status_q <= SAFE;
                        fsm_q    <= S_DONE;
                    end else if (iters_q == MAX_CNT) begin
                        status_q <= TIMEOUT;
                        fsm_q    <= S_DONE;
                    end else begin
                        state_q <= next_state_d;
                        iters_q <= iters_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // First DONE cycle only registers res_valid; the handshake follows
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        fsm_q   <= S_IDLE;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready = ready_q;
    assign bus.res_valid   = valid_q;
    assign bus.res_status  = status_q;
    assign bus.res_state   = state_q;
    assign bus.res_iters   = iters_q;

endmodule
